// File: rtl/dslp_pkg.sv
// rtl/dslp_pkg.sv - shared types and seven-segment codes for the dual-slope ADC sequencer
package dslp_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DISCH = 3'd1,
        INTEG = 3'd2,
        DEINT = 3'd3,
        LATCH = 3'd4
    } state_t;

    typedef logic [3:0] bcd_t;

    // Segment order {g,f,e,d,c,b,a}, active high
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic logic [6:0] seg_of(input bcd_t d);
        case (d)
            4'd0:    seg_of = SEG_0;
            4'd1:    seg_of = SEG_1;
            4'd2:    seg_of = SEG_2;
            4'd3:    seg_of = SEG_3;
            4'd4:    seg_of = SEG_4;
            4'd5:    seg_of = SEG_5;
            4'd6:    seg_of = SEG_6;
            4'd7:    seg_of = SEG_7;
            4'd8:    seg_of = SEG_8;
            4'd9:    seg_of = SEG_9;
            default: seg_of = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/dslp_adc_seq_bcd_counter.sv
// rtl/dslp_adc_seq_bcd_counter.sv - N-digit BCD up-counter shared by integrate and de-integrate phases
module dslp_bcd_counter
    import dslp_pkg::*;
#(
    parameter int DIGITS = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clr_i,
    input  logic                en_i,
    output logic [4*DIGITS-1:0] value_o,
    output logic                at_max_o
);

    logic [4*DIGITS-1:0] value_q;
    logic [4*DIGITS-1:0] value_d;
    logic                carry;

    always_comb begin
        value_d = value_q;
        carry   = en_i;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (bcd_t'(value_q[4*i +: 4]) == 4'd9) begin
                    value_d[4*i +: 4] = 4'd0;
                end else begin
                    value_d[4*i +: 4] = value_q[4*i +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
        if (clr_i) value_d = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) value_q <= '0;
        else        value_q <= value_d;
    end

    assign value_o  = value_q;
    assign at_max_o = (value_q == {DIGITS{4'h9}});

endmodule

// File: rtl/dslp_adc_seq.sv
// rtl/dslp_adc_seq.sv - dual-slope ADC sequencer with BCD result; DSLP_SSG_EN adds the ssg display output
module dslp_adc_seq
    import dslp_pkg::*;
#(
    parameter int DIGITS    = 3,
    parameter int DISCH_MAX = 4096,
    parameter int CONT      = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                cap_discharged,
    input  logic                cmp_pos,
    output logic                ch_zero,
    output logic                ch_vmeas,
    output logic                ch_vref_p,
    output logic                ch_vref_n,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] result_bcd,
    output logic                result_neg,
    output logic                overrange,
    output logic                timeout
`ifdef DSLP_SSG_EN
    ,
    output logic [7*DIGITS-1:0] ssg
`endif
);

    localparam int DISCH_W = (DISCH_MAX > 2) ? $clog2(DISCH_MAX) : 1;
    localparam logic [DISCH_W-1:0] DISCH_LAST = DISCH_W'(DISCH_MAX - 1);

    state_t              state_q;
    logic [DISCH_W-1:0]  disch_q;
    logic                pol_q;
    logic [1:0]          cd_s_q, cmp_s_q;
    logic                cd_sync, cmp_sync;
    logic                cnt_en, cnt_clr, cnt_at_max;
    logic [4*DIGITS-1:0] cnt_val;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cd_s_q  <= '0;
            cmp_s_q <= '0;
        end else begin
            cd_s_q  <= {cd_s_q[0], cap_discharged};
            cmp_s_q <= {cmp_s_q[0], cmp_pos};
        end
    end

    assign cd_sync  = cd_s_q[1];
    assign cmp_sync = cmp_s_q[1];

    // Counter restarts from zero at the INTEG->DEINT boundary
    assign cnt_en  = (state_q == INTEG) || (state_q == DEINT);
    assign cnt_clr = !cnt_en || ((state_q == INTEG) && cnt_at_max);

    dslp_bcd_counter #(.DIGITS(DIGITS)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (cnt_clr),
        .en_i     (cnt_en),
        .value_o  (cnt_val),
        .at_max_o (cnt_at_max)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            disch_q    <= '0;
            pol_q      <= 1'b0;
            ch_zero    <= 1'b0;
            ch_vmeas   <= 1'b0;
            ch_vref_p  <= 1'b0;
            ch_vref_n  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            result_bcd <= '0;
            result_neg <= 1'b0;
            overrange  <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= DISCH;
                        disch_q <= '0;
                        ch_zero <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                DISCH: begin
                    if (cd_sync) begin
                        state_q  <= INTEG;
                        ch_zero  <= 1'b0;
                        ch_vmeas <= 1'b1;
                    end else if (disch_q == DISCH_LAST) begin
                        state_q   <= LATCH;
                        ch_zero   <= 1'b0;
                        timeout   <= 1'b1;
                        overrange <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        disch_q <= disch_q + 1'b1;
                    end
                end
                INTEG: begin
                    if (cnt_at_max) begin
                        state_q   <= DEINT;
                        pol_q     <= cmp_sync;
                        ch_vmeas  <= 1'b0;
                        ch_vref_n <= cmp_sync;
                        ch_vref_p <= !cmp_sync;
                    end
                end
                DEINT: begin
                    // A zero cross on the full-scale cycle still counts as a valid reading
                    if ((cmp_sync != pol_q) || cnt_at_max) begin
                        state_q    <= LATCH;
                        ch_vref_p  <= 1'b0;
                        ch_vref_n  <= 1'b0;
                        done       <= 1'b1;
                        timeout    <= 1'b0;
                        result_neg <= !pol_q;
                        if (cmp_sync != pol_q) begin
                            result_bcd <= cnt_val;
                            overrange  <= 1'b0;
                        end else begin
                            result_bcd <= {DIGITS{4'h9}};
                            overrange  <= 1'b1;
                        end
                    end
                end
                LATCH: begin
                    if (CONT != 0) begin
                        state_q <= DISCH;
                        disch_q <= '0;
                        ch_zero <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef DSLP_SSG_EN
    logic [7*DIGITS-1:0] ssg_d;
    logic                lead;

    always_comb begin
        ssg_d = '0;
        lead  = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (lead && (i != 0) && (result_bcd[4*i +: 4] == 4'd0)) begin
                ssg_d[7*i +: 7] = SEG_BLANK;
            end else begin
                lead            = 1'b0;
                ssg_d[7*i +: 7] = seg_of(result_bcd[4*i +: 4]);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ssg <= '0;
        else        ssg <= ssg_d;
    end
`endif

endmodule

// File: tb/tb_dslp_adc_seq.sv
// tb/tb_dslp_adc_seq.sv - randomized self-checking bench for dslp_adc_seq (DIGITS=2, DISCH_MAX=64)
module tb_dslp_adc_seq;

    localparam int DIGITS    = 2;
    localparam int DISCH_MAX = 64;
    localparam int INT_CNT   = 100;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0, cap_discharged = 1'b0, cmp_pos = 1'b0;
    logic       ch_zero, ch_vmeas, ch_vref_p, ch_vref_n, busy, done;
    logic [7:0] result_bcd;
    logic       result_neg, overrange, timeout;

    logic       start2 = 1'b0, cap2 = 1'b1, cmp2 = 1'b1;
    logic       z2, vm2, vp2, vn2, busy2, done2;
    logic [7:0] res2;
    logic       neg2, over2, to2;
`ifdef DSLP_SSG_EN
    logic [13:0] ssg, ssg2;
`endif

    dslp_adc_seq #(.DIGITS(DIGITS), .DISCH_MAX(DISCH_MAX), .CONT(0)) dut (
        .clk(clk), .reset(reset), .start(start), .cap_discharged(cap_discharged), .cmp_pos(cmp_pos),
        .ch_zero(ch_zero), .ch_vmeas(ch_vmeas), .ch_vref_p(ch_vref_p), .ch_vref_n(ch_vref_n),
        .busy(busy), .done(done), .result_bcd(result_bcd), .result_neg(result_neg),
        .overrange(overrange), .timeout(timeout)
`ifdef DSLP_SSG_EN
        , .ssg(ssg)
`endif
    );

    dslp_adc_seq #(.DIGITS(DIGITS), .DISCH_MAX(DISCH_MAX), .CONT(1)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .cap_discharged(cap2), .cmp_pos(cmp2),
        .ch_zero(z2), .ch_vmeas(vm2), .ch_vref_p(vp2), .ch_vref_n(vn2),
        .busy(busy2), .done(done2), .result_bcd(res2), .result_neg(neg2),
        .overrange(over2), .timeout(to2)
`ifdef DSLP_SSG_EN
        , .ssg(ssg2)
`endif
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int n_zero = 0, n_vmeas = 0, n_vrefp = 0, n_vrefn = 0, n_done = 0, n_multi = 0;
    logic [7:0] exp_bcd = 8'h00;
    logic       exp_neg = 1'b0;

    always @(negedge clk) begin
        if (ch_zero)   n_zero++;
        if (ch_vmeas)  n_vmeas++;
        if (ch_vref_p) n_vrefp++;
        if (ch_vref_n) n_vrefn++;
        if (done)      n_done++;
        if (int'(ch_zero) + int'(ch_vmeas) + int'(ch_vref_p) + int'(ch_vref_n) > 1) n_multi++;
    end

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] hi, lo;
        hi = 4'((v / 10) % 10);
        lo = 4'(v % 10);
        return {hi, lo};
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({ch_zero, ch_vmeas, ch_vref_p, ch_vref_n, busy, done, result_bcd, result_neg, overrange, timeout} !== 17'd0) begin
            bad++;
            $display("FAIL reset_state: got outputs %b, want all zero",
                {ch_zero, ch_vmeas, ch_vref_p, ch_vref_n, busy, done, result_bcd, result_neg, overrange, timeout});
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    // flip_at < 0: comparator never crosses (overrange expected)
    task automatic test_conv(input string name, input logic pol, input int cap_dly, input int flip_at, input bit poke);
        int z0, v0, p0, n0, d0, m0, wc;
        int exp_vref;
        logic [7:0] want_bcd;
        cmp_pos = pol;
        cap_discharged = 1'b0;
        v0 = n_vmeas; p0 = n_vrefp; n0 = n_vrefn; d0 = n_done; m0 = n_multi; z0 = n_zero;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (cap_dly) @(negedge clk);
        cap_discharged = 1'b1;
        if (poke) begin
            wc = 0;
            while (!ch_vmeas && wc < 200) begin @(negedge clk); wc++; end
            repeat (10) @(negedge clk);
            start = 1'b1;
            @(negedge clk) start = 1'b0;
        end
        wc = 0;
        while (!(ch_vref_p || ch_vref_n) && wc < 400) begin @(negedge clk); wc++; end
        total++;
        if (!(ch_vref_p || ch_vref_n)) begin
            bad++;
            $display("FAIL %s deint_entry: no reference switch after %0d cycles", name, wc);
        end
        if (flip_at >= 0) begin
            repeat (flip_at) @(negedge clk);
            cmp_pos = ~pol;
        end
        wc = 0;
        while (!done && wc < 300) begin @(negedge clk); wc++; end
        want_bcd = (flip_at >= 0) ? to_bcd(flip_at + 2) : 8'h99;
        exp_vref = (flip_at >= 0) ? flip_at + 3 : INT_CNT;
        total++;
        if (done !== 1'b1 || result_bcd !== want_bcd || overrange !== (flip_at < 0) || timeout !== 1'b0) begin
            bad++;
            $display("FAIL %s result: done=%b bcd=%h ovr=%b to=%b, want done=1 bcd=%h ovr=%b to=0",
                name, done, result_bcd, overrange, timeout, want_bcd, flip_at < 0);
        end
        if (flip_at >= 0) begin
            total++;
            if (result_neg !== ~pol) begin
                bad++;
                $display("FAIL %s sign: got %b want %b", name, result_neg, ~pol);
            end
            exp_bcd = want_bcd;
            exp_neg = ~pol;
        end
        repeat (3) @(negedge clk);
        cap_discharged = 1'b0;
        total++;
        if (n_vmeas - v0 !== INT_CNT) begin
            bad++;
            $display("FAIL %s vmeas_len: got %0d want %0d", name, n_vmeas - v0, INT_CNT);
        end
        total++;
        if ((pol ? n_vrefn - n0 : n_vrefp - p0) !== exp_vref || (pol ? n_vrefp - p0 : n_vrefn - n0) !== 0) begin
            bad++;
            $display("FAIL %s vref_len: p=%0d n=%0d want %0d on %s", name, n_vrefp - p0, n_vrefn - n0,
                exp_vref, pol ? "vref_n" : "vref_p");
        end
        total++;
        if (n_done - d0 !== 1 || busy !== 1'b0 || n_multi !== m0 || n_zero - z0 < 1) begin
            bad++;
            $display("FAIL %s handshake: done_pulses=%0d busy=%b overlap=%0d want 1/0/0",
                name, n_done - d0, busy, n_multi - m0);
        end
    endtask

    task automatic test_timeout();
        int z0, v0, d0, wc;
        cap_discharged = 1'b0;
        cmp_pos = 1'($urandom_range(0, 1));
        z0 = n_zero; v0 = n_vmeas; d0 = n_done;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        wc = 0;
        while (!done && wc < 200) begin @(negedge clk); wc++; end
        total++;
        if (done !== 1'b1 || timeout !== 1'b1 || overrange !== 1'b0 || result_bcd !== exp_bcd || result_neg !== exp_neg) begin
            bad++;
            $display("FAIL timeout_latch: done=%b to=%b ovr=%b bcd=%h neg=%b, want 1/1/0/%h/%b",
                done, timeout, overrange, result_bcd, result_neg, exp_bcd, exp_neg);
        end
        repeat (3) @(negedge clk);
        total++;
        if (n_zero - z0 !== DISCH_MAX || n_vmeas - v0 !== 0 || n_done - d0 !== 1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL timeout_len: zero=%0d vmeas=%0d done=%0d busy=%b, want %0d/0/1/0",
                n_zero - z0, n_vmeas - v0, n_done - d0, busy, DISCH_MAX);
        end
    endtask

    task automatic test_reset_mid();
        int wc;
        cmp_pos = 1'b1;
        cap_discharged = 1'b1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        wc = 0;
        while (!(ch_vref_p || ch_vref_n) && wc < 400) begin @(negedge clk); wc++; end
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        total++;
        if ({ch_zero, ch_vmeas, ch_vref_p, ch_vref_n, busy, done, result_bcd, result_neg, overrange, timeout} !== 17'd0) begin
            bad++;
            $display("FAIL reset_mid: got outputs %b, want all zero",
                {ch_zero, ch_vmeas, ch_vref_p, ch_vref_n, busy, done, result_bcd, result_neg, overrange, timeout});
        end
        @(negedge clk) reset = 1'b1;
        cap_discharged = 1'b0;
        exp_bcd = 8'h00;
        exp_neg = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int dones, drops, wc;
        bit seen;
        dones = 0; drops = 0; seen = 1'b0;
        @(negedge clk) start2 = 1'b1;
        @(negedge clk) start2 = 1'b0;
        wc = 0;
        while (dones < 2 && wc < 900) begin
            if (busy2) seen = 1'b1;
            else if (seen) drops++;
            if (done2) dones++;
            @(negedge clk);
            wc++;
        end
        total++;
        if (dones !== 2 || drops !== 0 || busy2 !== 1'b1) begin
            bad++;
            $display("FAIL back_to_back: dones=%0d busy_drops=%0d busy=%b, want 2/0/1", dones, drops, busy2);
        end
        total++;
        if (res2 !== 8'h99 || over2 !== 1'b1 || to2 !== 1'b0) begin
            bad++;
            $display("FAIL back_to_back_result: bcd=%h ovr=%b to=%b, want 99/1/0", res2, over2, to2);
        end
    endtask

`ifdef DSLP_SSG_EN
    task automatic test_ssg();
        test_conv("ssg_05", 1'b1, 4, 3, 1'b0);
        total++;
        if (ssg !== {7'h00, 7'h6D}) begin
            bad++;
            $display("FAIL ssg_05: got %h want %h", ssg, {7'h00, 7'h6D});
        end
    endtask
`endif

    initial begin
        test_reset();
        test_conv("overrange", 1'b1, 10, -1, 1'b0);
        test_conv("pos_flip37", 1'b1, 10, 37, 1'b0);
        test_conv("neg_flip50", 1'b0, 10, 50, 1'b0);
        for (int k = 0; k < 4; k++) begin
            test_conv("random", 1'($urandom_range(0, 1)), int'($urandom_range(1, 30)),
                int'($urandom_range(0, 90)), 1'b0);
        end
        test_timeout();
        test_conv("start_in_integ", 1'($urandom_range(0, 1)), 6, int'($urandom_range(0, 90)), 1'b1);
        test_reset_mid();
        test_back_to_back();
`ifdef DSLP_SSG_EN
        test_ssg();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
